// File: rtl/fir_mac_scheduler.sv
// Time-shared FIR: one multiplier and accumulator served round-robin across CH channels.
// Define FIR_SCHED_SAT_EN to saturate the output instead of two's-complement wrapping.
module fir_mac_scheduler #(
   parameter  int DW   = 10,
   parameter  int TAPS = 27,
   parameter  int CH   = 4,
   localparam int AW   = $clog2(TAPS),
   localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH-1:0]    in_valid,
   input  logic [CH*DW-1:0] in_data,
   output logic [CH-1:0]    in_ready,
   input  logic             coef_we,
   input  logic [AW-1:0]    coef_addr,
   input  logic [DW-1:0]    coef_data,
   output logic             coef_busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_ch,
   output logic [DW-1:0]    out_data
);
   localparam int ACCW = 2*DW + AW;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t state, state_nx;

   logic signed [DW-1:0]   dl [CH][TAPS];
   logic [AW-1:0]          wptr [CH];
   logic signed [DW-1:0]   coef [TAPS];
   logic [CW-1:0]          last;
   logic [CW-1:0]          chl;
   logic [CW-1:0]          gidx;
   logic                   found;
   logic [AW-1:0]          tap;
   logic [AW-1:0]          wp;
   logic [AW-1:0]          ridx;
   logic                   tap_end;
   logic signed [2*DW-1:0] prod;
   logic signed [ACCW-1:0] acc;
   logic [DW-1:0]          narrow;

   // First requester after the last-granted channel, in cyclic order
   always_comb begin
      found = 1'b0;
      gidx  = last;
      for (int i = 1; i <= CH; i++) begin
         if (!found && in_valid[(int'(last) + i) % CH]) begin
            found = 1'b1;
            gidx  = CW'((int'(last) + i) % CH);
         end
      end
   end

   assign wp      = wptr[chl];
   assign tap_end = (tap == AW'(TAPS - 1));

   // x[n-k] lives k slots behind the not-yet-advanced write pointer
   always_comb begin
      if (wp >= tap) ridx = wp - tap;
      else           ridx = AW'(int'(wp) + TAPS - int'(tap));
   end

   assign prod = dl[chl][ridx] * coef[tap];

`ifdef FIR_SCHED_SAT_EN
   localparam logic signed [ACCW-1:0] SMAX = ACCW'((1 << (DW - 1)) - 1);
   localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

   logic signed [ACCW-1:0] sh;

   assign sh = acc >>> (DW - 1);

   always_comb begin
      narrow = sh[DW-1:0];
      unique case (1'b1)
         (sh > SMAX): narrow = SMAX[DW-1:0];
         (sh < SMIN): narrow = SMIN[DW-1:0];
         default: ;
      endcase
   end
`else
   always_comb begin
      narrow = acc[DW-1 +: DW];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (found) state_nx = MAC;
         MAC:     if (tap_end) state_nx = OUT;
         OUT:     if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = '0;
      coef_busy = (state != IDLE);
      out_valid = (state == OUT);
      out_ch    = '0;
      out_data  = '0;
      if (state == IDLE && found) in_ready[gidx] = 1'b1;
      if (state == OUT) begin
         out_ch   = chl;
         out_data = narrow;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            wptr[c] <= '0;
            for (int k = 0; k < TAPS; k++) dl[c][k] <= '0;
         end
         for (int k = 0; k < TAPS; k++) coef[k] <= '0;
         last <= CW'(CH - 1);
         chl  <= '0;
         tap  <= '0;
         acc  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (coef_we && int'(coef_addr) < TAPS)
                  coef[coef_addr] <= coef_data;
               if (found) begin
                  dl[gidx][wptr[gidx]] <= in_data[gidx*DW +: DW];
                  chl  <= gidx;
                  last <= gidx;
                  acc  <= '0;
                  tap  <= '0;
               end
            end
            MAC: begin
               acc <= acc + {{AW{prod[2*DW-1]}}, prod};
               tap <= tap + 1'b1;
               if (tap_end)
                  wptr[chl] <= (wp == AW'(TAPS - 1)) ? '0 : wp + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler (TAPS=4, CH=2).
// Expected outputs are queued at issue time; a negedge monitor pops and compares.
module tb_fir_mac_scheduler;
   localparam int DW   = 10;
   localparam int TAPS = 4;
   localparam int CH   = 2;
   localparam int AW   = 2;
   localparam int CW   = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [CH-1:0]    in_valid;
   logic [CH*DW-1:0] in_data;
   logic [CH-1:0]    in_ready;
   logic             coef_we;
   logic [AW-1:0]    coef_addr;
   logic [DW-1:0]    coef_data;
   logic             coef_busy;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    out_ch;
   logic [DW-1:0]    out_data;

   fir_mac_scheduler #(.DW(DW), .TAPS(TAPS), .CH(CH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .coef_busy(coef_busy),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch), .out_data(out_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CW-1:0] ch;
      logic [DW-1:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   logic prev_ov = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input int d);
      exp_t e;
      e.ch = CW'(c);
      e.d  = DW'(d);
      exp_q.push_back(e);
   endtask

   // Monitor: grant sanity, accept-to-valid latency, scoreboard compare
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (|in_ready) begin
            chk("in_ready_onehot", $countones(in_ready), 1);
            chk("in_ready_idle", int'(coef_busy), 0);
            acc_cyc = cyc;
         end
         if (out_valid && !prev_ov)
            chk("latency", cyc - acc_cyc, TAPS + 1);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("out_ch", int'(out_ch), int'(e.ch));
               chk("out_data", int'($signed(out_data)), int'($signed(e.d)));
            end
         end
      end
      prev_ov = out_valid;
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_ch", int'(out_ch), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_coef_busy", int'(coef_busy), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wcoefs(input int c0, input int c1, input int c2, input int c3);
      int v[4];
      v = '{c0, c1, c2, c3};
      for (int i = 0; i < 4; i++) begin
         coef_we   = 1'b1;
         coef_addr = AW'(i);
         coef_data = DW'(v[i]);
         @(posedge clk);
         #1;
      end
      coef_we = 1'b0;
   endtask

   task automatic grant_wait(output logic [CH-1:0] g);
      g = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (|in_ready) begin
            g = in_ready;
            break;
         end
      end
      if (g == '0) chk("grant_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int c, input int d);
      logic [CH-1:0] g;
      in_data[c*DW +: DW] = DW'(d);
      in_valid[c] = 1'b1;
      grant_wait(g);
      in_valid[c] = 1'b0;
      chk("send_grant", int'(g), 1 << c);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [CH-1:0] g;
      int ov[4];
      rst = 1'b1;
      in_valid = '0;
      in_data = '0;
      coef_we = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      out_ready = 1'b1;
      do_reset();

      // Impulse on ch0 interleaved with ch1 zeros via round-robin
      wcoefs(256, 128, 64, 32);
      push(0, 128); push(1, 0); push(0, 64); push(1, 0);
      in_data = '0;
      in_data[DW-1:0] = DW'(256);
      in_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         grant_wait(g);
         chk("rr_order", int'(g), (i % 2 == 0) ? 1 : 2);
         if (i == 0) in_data[DW-1:0] = '0;
      end
      in_valid = '0;
      push(0, 32); send(0, 0);
      push(0, 16); send(0, 0);
      push(0, 0);  send(0, 0);
      drain();

      // Backpressure on a ch1 result while ch0 waits
      out_ready = 1'b0;
      push(1, 128);
      send(1, 256);
      in_data[DW-1:0] = '0;
      in_valid[0] = 1'b1;
      push(0, 0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk("bp_valid_seen", int'(out_valid), 1);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_data", int'($signed(out_data)), 128);
         chk("bp_ch", int'(out_ch), 1);
         chk("bp_in_ready", int'(in_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      grant_wait(g);
      in_valid[0] = 1'b0;
      chk("bp_resume_grant", int'(g), 1);
      drain();

      // Overflow: 511*511 accumulated over a growing window
`ifdef FIR_SCHED_SAT_EN
      ov = '{510, 511, 511, 511};
`else
      ov = '{510, -4, 506, -8};
`endif
      do_reset();
      wcoefs(511, 511, 511, 511);
      for (int i = 0; i < 4; i++) begin
         push(0, ov[i]);
         send(0, 511);
      end
      drain();

      // Reset in the middle of MAC, then coefficient rules
      do_reset();
      wcoefs(256, 128, 64, 32);
      send(0, 256);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mac_rst_out_valid", int'(out_valid), 0);
      chk("mac_rst_coef_busy", int'(coef_busy), 0);
      @(posedge clk);
      #1;
      push(0, 0); send(0, 256);
      push(0, 0); send(0, 0);
      drain();
      wcoefs(256, 128, 64, 32);
      push(0, 32); send(0, 0);
      drain();
      push(0, 16); send(0, 0);
      chk("busy_during_mac", int'(coef_busy), 1);
      coef_we = 1'b1;
      coef_addr = AW'(3);
      coef_data = '0;
      @(posedge clk);
      #1 coef_we = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
      $fatal(1);
   end

endmodule
